// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: fetch squash FSM states,
// pipeline register indices and the debug stall-cause encoding.
// Pure declarations, no logic.
package hazard_pkg;

   // Fetch tracker: DROP means one wrong-path fetch is still in flight.
   typedef enum logic {
      RUN  = 1'b0,
      DROP = 1'b1
   } fetch_state_t;

   // Pipeline register indices.
   localparam int IF_ID  = 0;
   localparam int ID_EX  = 1;
   localparam int EX_MEM = 2;
   localparam int MEM_WB = 3;

   // Winning action for the current cycle, highest priority first after reset.
   typedef enum logic [2:0] {
      CAUSE_NONE     = 3'd0,
      CAUSE_RESET    = 3'd1,
      CAUSE_MC       = 3'd2,
      CAUSE_MEM      = 3'd3,
      CAUSE_IF       = 3'd4,
      CAUSE_SQUASH   = 3'd5,
      CAUSE_REDIRECT = 3'd6,
      CAUSE_LOAD_USE = 3'd7
   } stall_cause_t;

   // True for the causes that freeze every pipeline register and the PC.
   function automatic logic is_full_stall(input stall_cause_t c);
      return (c == CAUSE_MC) || (c == CAUSE_MEM) || (c == CAUSE_IF);
   endfunction

endpackage

// File: rtl/hazard_perf_ctr.sv
// Saturating event counter: counts cycles with inc high, sticks at all-ones.
// Latency: count reflects an event on the clock edge that follows it.
// No backpressure; inc is sampled every cycle.
module hazard_perf_ctr #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Increment until all-ones, then hold; never wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/hazard_ctrl_gen2.sv
// Pipeline hazard/stall controller: per-stage load/clear enables, PC load, stall flag.
// Latency: enables are combinational; busy bits, fetch FSM and counters update next edge.
// Any multi-cycle unit, D-cache miss or missing fetch freezes the whole pipeline.
module hazard_ctrl_gen2
   import hazard_pkg::*;
#(
   parameter int NUM_STAGES     = 4,
   parameter int NUM_MC         = 1,
   parameter int REDIRECT_STAGE = 2,
   parameter int BUBBLE_STAGE   = 1,
   parameter int EARLY_REDIRECT = 0,
   parameter int CNT_W          = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  icache_resp,
   input  logic                  dcache_req,
   input  logic                  dcache_resp,
   input  logic                  redirect,
   input  logic                  load_use,
   input  logic [NUM_MC-1:0]     mc_start,
   input  logic [NUM_MC-1:0]     mc_resp,
   output logic [NUM_STAGES-1:0] load_stage,
   output logic [NUM_STAGES-1:0] rst_stage,
   output logic                  load_pc,
   output logic                  is_stalling,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_count
);

   localparam logic EARLY = (EARLY_REDIRECT != 0);

   logic [NUM_MC-1:0] mc_busy;
   fetch_state_t      fetch_state;
   stall_cause_t      cause;
   logic              mc_stall;
   logic              mem_stall;
   logic              if_stall;
   logic              flush_inc;

   // A unit stalls from the cycle it accepts work until the cycle its result
   // appears; the result cycle itself is already free to advance.
   assign mc_stall  = |((mc_busy | mc_start) & ~mc_resp);
   assign mem_stall = dcache_req & ~dcache_resp;
   // In early mode a redirect does not wait for the pending fetch; the stale
   // fetch is squashed later by the DROP state instead.
   assign if_stall  = ~icache_resp & ~(EARLY & redirect);

   // Priority encode this cycle's winning action.
   always_comb begin
      cause = CAUSE_NONE;
      if (rst) begin
         cause = CAUSE_RESET;
      end else if (mc_stall) begin
         cause = CAUSE_MC;
      end else if (mem_stall) begin
         cause = CAUSE_MEM;
      end else if (if_stall) begin
         cause = CAUSE_IF;
      end else if ((fetch_state == DROP) && icache_resp) begin
         cause = CAUSE_SQUASH;
      end else if (redirect) begin
         cause = CAUSE_REDIRECT;
      end else if (load_use) begin
         cause = CAUSE_LOAD_USE;
      end
   end

   // Decode the winning action into register enables.
   always_comb begin
      load_stage  = '1;
      rst_stage   = '0;
      load_pc     = 1'b1;
      is_stalling = is_full_stall(cause);
      case (cause)
         CAUSE_RESET: begin
            load_stage = '0;
            load_pc    = 1'b0;
         end
         CAUSE_MC, CAUSE_MEM, CAUSE_IF: begin
            load_stage = '0;
            load_pc    = 1'b0;
         end
         CAUSE_SQUASH: begin
            // The wrong-path instruction lands in IF/ID as a bubble. The PC
            // already holds the redirect target, so it is held -- unless a new
            // redirect arrives now, whose target must be taken.
            rst_stage[IF_ID] = 1'b1;
            load_pc          = redirect;
            if (redirect) begin
               for (int k = 0; k < NUM_STAGES; k++) begin
                  if (k < REDIRECT_STAGE) rst_stage[k] = 1'b1;
               end
            end
         end
         CAUSE_REDIRECT: begin
            for (int k = 0; k < NUM_STAGES; k++) begin
               rst_stage[k] = (k < REDIRECT_STAGE);
            end
         end
         CAUSE_LOAD_USE: begin
            // Hold everything upstream of the bubble, clear the bubble register.
            load_pc = 1'b0;
            for (int k = 0; k < NUM_STAGES; k++) begin
               if (k < BUBBLE_STAGE) load_stage[k] = 1'b0;
            end
            rst_stage[BUBBLE_STAGE] = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign flush_inc = redirect & ((cause == CAUSE_REDIRECT) || (cause == CAUSE_SQUASH));

   // Per-unit busy bits; a same-cycle start and result leaves the unit idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mc_busy <= '0;
      end else begin
         mc_busy <= (mc_busy | mc_start) & ~mc_resp;
      end
   end

   // Fetch squash tracker: at most one wrong-path fetch is ever outstanding.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_state <= RUN;
      end else begin
         case (fetch_state)
            RUN: begin
               if ((cause == CAUSE_REDIRECT) && EARLY && !icache_resp) begin
                  fetch_state <= DROP;
               end
            end
            DROP: begin
               // A redirect here (no fetch yet) keeps the same single squash.
               if (cause == CAUSE_SQUASH) begin
                  fetch_state <= RUN;
               end
            end
            default: fetch_state <= RUN;
         endcase
      end
   end

   hazard_perf_ctr #(.CNT_W(CNT_W)) u_stall_ctr (
      .clk   (clk),
      .rst   (rst),
      .inc   (is_stalling),
      .count (stall_cycles)
   );

   hazard_perf_ctr #(.CNT_W(CNT_W)) u_flush_ctr (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_inc),
      .count (flush_count)
   );

endmodule
